fp_mul_mant_core: RTL and testbench

FP_MUL_MANT_CORE -- requirements
Module: fp_mul_mant_core

---
 rtl/fp_mul_mant_pkg.sv | 22 ++
 rtl/fp_mul_mant_core_unpack.sv | 28 ++
 rtl/fp_mul_mant_core.sv | 162 ++++++++++++++++
 tb/tb_fp_mul_mant_core.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_mant_pkg.sv
// Shared constants and state encoding for the single-precision multiplier
// mantissa core and its downstream normaliser.
package fp_mul_mant_pkg;

   localparam int unsigned BIAS   = 127;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned EXP_W  = 8;
   localparam int unsigned PROD_W = 50;

   localparam int unsigned WORD_W    = 1 + EXP_W + FRAC_W;
   localparam int unsigned SIG_W     = FRAC_W + 1;
   localparam int unsigned MANT_W    = 2 * SIG_W;
   localparam int unsigned CNT_W     = 5;
   localparam int unsigned ITER_LAST = SIG_W - 1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/fp_mul_mant_core_unpack.sv
// Combinational IEEE-754 single unpacker: fields plus zero/inf/nan class.
// Denormals are classed as zero and get a zero significand.
module fp_unpack
   import fp_mul_mant_pkg::*;
(
   input  logic [WORD_W-1:0] op,
   output logic              sign,
   output logic [EXP_W-1:0]  exp,
   output logic [SIG_W-1:0]  sgnf,
   output logic              is_zero,
   output logic              is_inf,
   output logic              is_nan
);

   logic [FRAC_W-1:0] frac;
   logic              exp_ones;

   assign sign     = op[WORD_W-1];
   assign exp      = op[WORD_W-2:FRAC_W];
   assign frac     = op[FRAC_W-1:0];
   assign exp_ones = &exp;

   assign is_zero = (exp == '0);
   assign is_inf  = exp_ones && (frac == '0);
   assign is_nan  = exp_ones && (frac != '0);
   assign sgnf    = is_zero ? '0 : {1'b1, frac};

endmodule

// File: rtl/fp_mul_mant_core.sv
// Sign/exponent/raw-mantissa stage of a single-precision multiplier. Specials
// resolve in one cycle; normal operands use a 24-step radix-2 shift-add.
module fp_mul_mant_core
   import fp_mul_mant_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] op_a,
   input  logic [WORD_W-1:0] op_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              sig,
   output logic [EXP_W-1:0]  exp_max,
   output logic [PROD_W-1:0] pre_pr_mant,
   output logic              NaN_res,
   output logic              inf_res
);

   localparam logic signed [9:0] EXP_OFS = 10'(BIAS - 1);
   localparam logic signed [9:0] EXP_TOP = 10'sd254;
   localparam logic signed [9:0] EXP_BOT = 10'sd1;

   logic              ua_sign, ub_sign;
   logic [EXP_W-1:0]  ua_exp, ub_exp;
   logic [SIG_W-1:0]  ua_sgnf, ub_sgnf;
   logic              ua_zero, ub_zero, ua_inf, ub_inf, ua_nan, ub_nan;

   fp_unpack u_unpack_a (
      .op      (op_a),
      .sign    (ua_sign),
      .exp     (ua_exp),
      .sgnf    (ua_sgnf),
      .is_zero (ua_zero),
      .is_inf  (ua_inf),
      .is_nan  (ua_nan)
   );

   fp_unpack u_unpack_b (
      .op      (op_b),
      .sign    (ub_sign),
      .exp     (ub_exp),
      .sgnf    (ub_sgnf),
      .is_zero (ub_zero),
      .is_inf  (ub_inf),
      .is_nan  (ub_nan)
   );

   state_e              state_q, state_d;
   logic [MANT_W-1:0]   mcand_q, mcand_d;
   logic [SIG_W-1:0]    mplier_q, mplier_d;
   logic [MANT_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                sig_q, sig_d;
   logic [EXP_W-1:0]    exp_q, exp_d;
   logic                nan_q, nan_d;
   logic                inf_q, inf_d;

   logic signed [9:0]   exp_sum;
   logic                nan_case, inf_case, zero_case;

   assign exp_sum   = $signed({2'b00, ua_exp}) + $signed({2'b00, ub_exp}) - EXP_OFS;
   assign nan_case  = ua_nan || ub_nan || (ua_inf && ub_zero) || (ub_inf && ua_zero);
   assign inf_case  = ua_inf || ub_inf;
   assign zero_case = ua_zero || ub_zero;

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sig_d    = sig_q;
      exp_d    = exp_q;
      nan_d    = nan_q;
      inf_d    = inf_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               sig_d    = ua_sign ^ ub_sign;
               mcand_d  = {{(MANT_W-SIG_W){1'b0}}, ua_sgnf};
               mplier_d = ub_sgnf;
               acc_d    = '0;
               cnt_d    = '0;
               exp_d    = '0;
               nan_d    = 1'b0;
               inf_d    = 1'b0;
               // Priority order keeps NaN_res and inf_res mutually exclusive.
               if (nan_case) begin
                  nan_d   = 1'b1;
                  exp_d   = '1;
                  state_d = StDone;
               end else if (inf_case) begin
                  inf_d   = 1'b1;
                  exp_d   = '1;
                  state_d = StDone;
               end else if (zero_case) begin
                  state_d = StDone;
               end else if (exp_sum > EXP_TOP) begin
                  inf_d   = 1'b1;
                  exp_d   = '1;
                  state_d = StDone;
               end else if (exp_sum < EXP_BOT) begin
                  state_d = StDone;
               end else begin
                  exp_d   = exp_sum[EXP_W-1:0];
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == CNT_W'(ITER_LAST)) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sig_q    <= 1'b0;
         exp_q    <= '0;
         nan_q    <= 1'b0;
         inf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sig_q    <= sig_d;
         exp_q    <= exp_d;
         nan_q    <= nan_d;
         inf_q    <= inf_d;
      end
   end

   assign in_ready    = (state_q == StIdle);
   assign out_valid   = (state_q == StDone);
   assign sig         = sig_q;
   assign exp_max     = exp_q;
   assign pre_pr_mant = {{(PROD_W-MANT_W){1'b0}}, acc_q};
   assign NaN_res     = nan_q;
   assign inf_res     = inf_q;

endmodule

// File: tb/tb_fp_mul_mant_core.sv
// Self-checking bench for fp_mul_mant_core: directed vector table, hold and
// mid-operation reset sequences, and random operands against a float model.
module tb_fp_mul_mant_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a, op_b;
   logic        out_valid;
   logic        out_ready;
   logic        sig;
   logic [7:0]  exp_max;
   logic [49:0] pre_pr_mant;
   logic        NaN_res, inf_res;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fp_mul_mant_core dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .sig         (sig),
      .exp_max     (exp_max),
      .pre_pr_mant (pre_pr_mant),
      .NaN_res     (NaN_res),
      .inf_res     (inf_res)
   );

   // lat = 0: latency not checked; chk_data = 0: exp/mant not checked.
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sig;
      logic [7:0]  exp;
      logic [49:0] mant;
      logic        nan;
      logic        inf;
      int          lat;
      bit          chk_data;
   } vec_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, got, want);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input logic [7:0] e, input logic [49:0] m, input logic n,
                               input logic i, input int lat, input bit chk);
      vec_t v;
      v.a = a; v.b = b; v.sig = s; v.exp = e; v.mant = m;
      v.nan = n; v.inf = i; v.lat = lat; v.chk_data = chk;
      return v;
   endfunction

   // Reference from IEEE-754 classification and integer arithmetic on the significands.
   function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
      vec_t v;
      int ea, eb, e;
      longint unsigned sa, sb;
      bit za, zb, ia, ib, na, nb;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      za = (ea == 0);
      zb = (eb == 0);
      ia = (ea == 255) && (a[22:0] == 0);
      ib = (eb == 255) && (b[22:0] == 0);
      na = (ea == 255) && (a[22:0] != 0);
      nb = (eb == 255) && (b[22:0] != 0);
      v = mk(a, b, a[31] ^ b[31], 8'd0, 50'd0, 1'b0, 1'b0, 1, 1'b1);
      if (na || nb || (ia && zb) || (ib && za)) begin
         v.nan = 1'b1; v.chk_data = 1'b0;
      end else if (ia || ib) begin
         v.inf = 1'b1; v.chk_data = 1'b0;
      end else if (!(za || zb)) begin
         e = ea + eb - 126;
         if (e > 254) begin
            v.inf = 1'b1; v.exp = 8'hFF; v.lat = 0;
         end else if (e < 1) begin
            v.lat = 0;
         end else begin
            sa = 64'(a[22:0]) + 64'h80_0000;
            sb = 64'(b[22:0]) + 64'h80_0000;
            v.exp  = 8'(e);
            v.mant = 50'(sa * sb);
            v.lat  = 25;
         end
      end
      return v;
   endfunction

   function automatic logic [31:0] rand_op();
      logic [7:0]  e;
      logic [22:0] f;
      int k;
      k = int'($urandom_range(0, 15));
      f = 23'($urandom);
      case (k)
         0: e = 8'h00;
         1: begin e = 8'hFF; if ($urandom_range(0, 1) == 1) f = '0; end
         2: e = 8'h01;
         3: e = 8'hFE;
         default: e = 8'($urandom_range(60, 194));
      endcase
      return {1'($urandom), e, f};
   endfunction

   task automatic run_op(input vec_t v, input int hold, input bit noisy, input string tag);
      logic        s0, n0, i0;
      logic [7:0]  e0;
      logic [49:0] m0;
      int          lat;
      bit          stable;
      @(negedge clk);
      check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      op_a = v.a; op_b = v.b; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         // Traffic while busy must be ignored.
         if (noisy && lat < 20) begin
            in_valid = 1'b1; op_a = $urandom; op_b = $urandom; out_ready = 1'b1;
         end else begin
            in_valid = 1'b0; out_ready = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      if (!out_valid) begin
         check({tag, ".out_valid_timeout"}, 64'(out_valid), 64'd1);
         return;
      end
      if (v.lat != 0) check({tag, ".latency"}, 64'(lat), 64'(v.lat));
      check({tag, ".sig"}, 64'(sig), 64'(v.sig));
      check({tag, ".NaN_res"}, 64'(NaN_res), 64'(v.nan));
      check({tag, ".inf_res"}, 64'(inf_res), 64'(v.inf));
      if (v.chk_data) begin
         check({tag, ".exp_max"}, 64'(exp_max), 64'(v.exp));
         check({tag, ".pre_pr_mant"}, 64'(pre_pr_mant), 64'(v.mant));
      end
      s0 = sig; e0 = exp_max; m0 = pre_pr_mant; n0 = NaN_res; i0 = inf_res;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         stable = out_valid && !in_ready && (sig == s0) && (exp_max == e0) &&
                  (pre_pr_mant == m0) && (NaN_res == n0) && (inf_res == i0);
         check({tag, ".hold"}, 64'(stable), 64'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, ".release"}, 64'({out_valid, in_ready}), 64'b01);
   endtask

   vec_t tbl[16];

   initial begin
      bit seen;
      vec_t v;

      tbl[0]  = mk(32'h3F800000, 32'h3F800000, 1'b0, 8'd128, 50'h0_4000_0000_0000, 0, 0, 25, 1);
      tbl[1]  = mk(32'h40000000, 32'hC0400000, 1'b1, 8'd130, 50'h0_6000_0000_0000, 0, 0, 25, 1);
      tbl[2]  = mk(32'h7FC00000, 32'h3F800000, 1'b0, 8'd0, 50'd0, 1, 0, 1, 0);
      tbl[3]  = mk(32'h7F800000, 32'h00000000, 1'b0, 8'd0, 50'd0, 1, 0, 1, 0);
      tbl[4]  = mk(32'h7F800000, 32'h40000000, 1'b0, 8'd0, 50'd0, 0, 1, 1, 0);
      tbl[5]  = mk(32'h7F000000, 32'h7F000000, 1'b0, 8'hFF, 50'd0, 0, 1, 0, 1);
      tbl[6]  = mk(32'h00800000, 32'h00800000, 1'b0, 8'd0, 50'd0, 0, 0, 0, 1);
      tbl[7]  = mk(32'h00000000, 32'hBF800000, 1'b1, 8'd0, 50'd0, 0, 0, 1, 1);
      tbl[8]  = mk(32'hFF800000, 32'h7FC00001, 1'b1, 8'd0, 50'd0, 1, 0, 1, 0);
      tbl[9]  = mk(32'h00000001, 32'h7F800000, 1'b0, 8'd0, 50'd0, 1, 0, 1, 0);
      tbl[10] = mk(32'h3FC00000, 32'h3FC00000, 1'b0, 8'd128, 50'h0_9000_0000_0000, 0, 0, 25, 1);
      tbl[11] = mk(32'h5F000000, 32'h5F000000, 1'b0, 8'd254, 50'h0_4000_0000_0000, 0, 0, 25, 1);
      tbl[12] = mk(32'h5F000000, 32'h5F800000, 1'b0, 8'hFF, 50'd0, 0, 1, 0, 1);
      tbl[13] = mk(32'h1F800000, 32'h20000000, 1'b0, 8'd1, 50'h0_4000_0000_0000, 0, 0, 25, 1);
      tbl[14] = mk(32'h1F800000, 32'h1F800000, 1'b0, 8'd0, 50'd0, 0, 0, 0, 1);
      tbl[15] = mk(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, 8'd128, 50'h0_FFFF_FE00_0001, 0, 0, 25, 1);

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset.in_ready", 64'(in_ready), 64'd1);
      check("reset.out_valid", 64'(out_valid), 64'd0);
      check("reset.data", 64'({sig, exp_max, NaN_res, inf_res}), 64'd0);
      check("reset.pre_pr_mant", 64'(pre_pr_mant), 64'd0);

      for (int i = 0; i < 16; i++) run_op(tbl[i], i % 3, 1'b0, $sformatf("vec%0d", i));

      // Long stall in DONE with busy-time traffic on the inputs.
      run_op(tbl[1], 10, 1'b1, "hold10");

      // Reset at iteration 12 must discard the operation.
      @(negedge clk);
      op_a = 32'h40000000; op_b = 32'hC0400000; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (12) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst.in_ready", 64'(in_ready), 64'd1);
      check("midrst.out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      check("midrst.pre_pr_mant", 64'(pre_pr_mant), 64'd0);
      check("midrst.data", 64'({sig, exp_max, NaN_res, inf_res}), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("midrst.no_out_valid", 64'(seen), 64'd0);
      run_op(model(32'h40400000, 32'h40A00000), 1, 1'b0, "after_rst");

      for (int i = 0; i < 40; i++) begin
         v = model(rand_op(), rand_op());
         run_op(v, int'($urandom_range(0, 3)), 1'($urandom), $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
